layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/nn_seq_pkg.sv | 7 +
 rtl/wrap_counter.sv | 19 +
 rtl/layer_sequencer.sv | 71 +++++++
 tb/tb_layer_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/nn_seq_pkg.sv
// nn_seq_pkg: shared state encoding and default widths for the layer sequencer
package nn_seq_pkg;
  localparam int IN_W_DEF = 7;
  localparam int NODE_W_DEF = 5;
  localparam int LAYER_W_DEF = 2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: up-counter that returns to zero after reaching max, flagging the wrap
module wrap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         wrap
);
  assign wrap = enable && count == max;
  // count on enable, restart at zero on wrap or clear
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: walks input/node/layer indices of a network pass with done pulses
module layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int NODE_W = NODE_W_DEF,
  parameter int LAYER_W = LAYER_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               coef_ready,
  input  logic [IN_W-1:0]    max_input,
  input  logic [NODE_W-1:0]  max_node,
  input  logic [LAYER_W-1:0] max_layer,
  output logic [IN_W-1:0]    input_num,
  output logic [NODE_W-1:0]  node_num,
  output logic [LAYER_W-1:0] layer_num,
  output logic               busy,
  output logic               node_done,
  output logic               layer_done,
  output logic               all_done
);
  state_t state;
  logic [IN_W-1:0] lim_i;
  logic [NODE_W-1:0] lim_n;
  logic [LAYER_W-1:0] lim_l;
  logic adv, clear, wi, wn, wl;
  assign adv = state == RUN && coef_ready && !abort;
  assign clear = state != RUN || abort;
  wrap_counter #(.W(IN_W)) u_input (
    .clk(clk), .rst(rst), .clear(clear), .enable(adv), .max(lim_i), .count(input_num), .wrap(wi)
  );
  wrap_counter #(.W(NODE_W)) u_node (
    .clk(clk), .rst(rst), .clear(clear), .enable(wi), .max(lim_n), .count(node_num), .wrap(wn)
  );
  wrap_counter #(.W(LAYER_W)) u_layer (
    .clk(clk), .rst(rst), .clear(clear), .enable(wn), .max(lim_l), .count(layer_num), .wrap(wl)
  );
  // pass control: latch limits on start, leave RUN on abort or final wrap, one DONE cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      node_done <= 1'b0;
      layer_done <= 1'b0;
      all_done <= 1'b0;
      lim_i <= '0;
      lim_n <= '0;
      lim_l <= '0;
    end else begin
      node_done <= wi;
      layer_done <= wn;
      all_done <= wl;
      unique case (state)
        IDLE: if (start && !abort) begin
          state <= RUN;
          busy <= 1'b1;
          lim_i <= max_input;
          lim_n <= max_node;
          lim_l <= max_layer;
        end
        RUN: if (abort || wl) begin
          state <= wl ? DONE : IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed and random passes checked against an advance-count model
module tb_layer_sequencer;
  localparam int IW = 7, NW = 5, LW = 2;
  logic clk = 0, rst = 1, start = 0, abort = 0, coef_ready = 0;
  logic [IW-1:0] max_input = 0;
  logic [NW-1:0] max_node = 0;
  logic [LW-1:0] max_layer = 0;
  logic [IW-1:0] input_num;
  logic [NW-1:0] node_num;
  logic [LW-1:0] layer_num;
  logic busy, node_done, layer_done, all_done;
  int checks = 0, errors = 0;
  int m_st = 0, c = 0, mi = 0, mn = 0, ml = 0;
  bit e_nd = 0, e_ld = 0, e_ad = 0;

  layer_sequencer #(.IN_W(IW), .NODE_W(NW), .LAYER_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .coef_ready(coef_ready),
    .max_input(max_input), .max_node(max_node), .max_layer(max_layer),
    .input_num(input_num), .node_num(node_num), .layer_num(layer_num),
    .busy(busy), .node_done(node_done), .layer_done(layer_done), .all_done(all_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int p1 = mi + 1;
    int p2 = p1 * (mn + 1);
    chk("busy", 32'(busy), 32'(m_st == 1));
    chk("input_num", 32'(input_num), m_st == 1 ? 32'(c % p1) : 0);
    chk("node_num", 32'(node_num), m_st == 1 ? 32'((c / p1) % (mn + 1)) : 0);
    chk("layer_num", 32'(layer_num), m_st == 1 ? 32'(c / p2) : 0);
    chk("node_done", 32'(node_done), 32'(e_nd));
    chk("layer_done", 32'(layer_done), 32'(e_ld));
    chk("all_done", 32'(all_done), 32'(e_ad));
  endtask

  task automatic model_reset();
    m_st = 0; c = 0; mi = 0; mn = 0; ml = 0;
    e_nd = 0; e_ld = 0; e_ad = 0;
  endtask

  task automatic tick();
    bit s = start, a = abort, r = coef_ready, rs = rst;
    int ni = int'(max_input), nn = int'(max_node), nl = int'(max_layer);
    @(posedge clk);
    #1;
    e_nd = 0; e_ld = 0; e_ad = 0;
    if (rs) model_reset();
    else case (m_st)
      0: if (s && !a) begin m_st = 1; c = 0; mi = ni; mn = nn; ml = nl; end
      1: if (a) begin m_st = 0; c = 0; end
         else if (r) begin
           c++;
           e_nd = c % (mi + 1) == 0;
           e_ld = c % ((mi + 1) * (mn + 1)) == 0;
           e_ad = c == (mi + 1) * (mn + 1) * (ml + 1);
           if (e_ad) begin m_st = 2; c = 0; end
         end
      default: m_st = 0;
    endcase
    check_all();
  endtask

  task automatic run_until_idle(input int bound);
    int n = 0;
    while (m_st != 0 && n < bound) begin tick(); n++; end
    if (m_st != 0) begin
      errors++;
      $error("FAIL timeout observed %0d cycles expected idle within %0d", n, bound);
    end
  endtask

  task automatic cfg(input int i, input int n, input int l);
    max_input = IW'(i); max_node = NW'(n); max_layer = LW'(l);
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    cfg(2, 1, 0);
    coef_ready = 1;
    start = 1;
    tick();
    start = 0;
    run_until_idle(50);
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    coef_ready = 0;
    repeat (3) tick();
    coef_ready = 1;
    run_until_idle(50);
    cfg(0, 0, 0);
    start = 1;
    tick();
    start = 0;
    run_until_idle(10);
    start = 1;
    abort = 1;
    tick();
    abort = 0;
    start = 0;
    cfg(5, 1, 0);
    start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    abort = 1;
    tick();
    abort = 0;
    start = 1;
    tick();
    start = 0;
    run_until_idle(50);
    cfg(1, 3, 2);
    start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 100 && c < 12; k++) tick();
    #2 rst = 1;
    #1 model_reset();
    check_all();
    tick();
    tick();
    rst = 0;
    repeat (40) tick();
    cfg(2, 1, 1);
    start = 1;
    tick();
    start = 0;
    max_input = 7;
    max_node = 4;
    run_until_idle(50);
    for (int p = 0; p < 25; p++) begin
      cfg($urandom_range(3), $urandom_range(2), $urandom_range(3));
      start = 1;
      tick();
      for (int k = 0; k < 1000 && m_st != 0; k++) begin
        start = 1'($urandom);
        coef_ready = ($urandom % 4) != 0;
        abort = ($urandom % 64) == 0;
        cfg($urandom_range(3), $urandom_range(2), $urandom_range(3));
        tick();
      end
      start = 0;
      abort = 0;
      coef_ready = 1;
      run_until_idle(10);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
